// File: rtl/liang_pkg.sv
// Shared types and constants for the pipeline issue/hazard controller.
package liang_pkg;

  typedef enum logic [1:0] {
    HZ_RUN   = 2'd0,
    HZ_FLUSH = 2'd1,
    HZ_HALT  = 2'd2
  } hz_state_e;

  localparam int HZ_NUM_REGS     = 32;
  localparam int HZ_MAX_INFLIGHT = 3;
  localparam int HZ_CW           = $clog2(HZ_MAX_INFLIGHT + 1);

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle of the decode/execute/writeback signals seen by the issue controller.
interface pipe_hazard_ctrl_if #(
  parameter int CW = liang_pkg::HZ_CW
);
  import liang_pkg::*;

  // ID -> EX handshake: an instruction moves from ID into EX in a cycle where
  // id_valid_i && issue_ok_o && ex_ready_i are all high. issue_ok_o never
  // depends on ex_ready_i, and a stalled instruction simply stays in ID.
  logic            id_valid_i;
  logic [4:0]      id_rs1_i;
  logic [4:0]      id_rs2_i;
  logic            id_rs1_en_i;
  logic            id_rs2_en_i;
  logic [4:0]      id_rd_i;
  logic            id_rd_wen_i;
  logic            id_fence_i;
  logic            ex_ready_i;
  logic            issue_ok_o;

  // Writeback / redirect events.
  logic            wb_valid_i;
  logic [4:0]      wb_rd_i;
  logic            wb_wen_i;
  logic            wb_ebreak_i;
  logic            redirect_i;

  // Status.
  logic            flush_o;
  logic            halted_o;
  logic [CW-1:0]   inflight_o;
  hz_state_e       state_o;

  modport master (
    output id_valid_i, id_rs1_i, id_rs2_i, id_rs1_en_i, id_rs2_en_i,
           id_rd_i, id_rd_wen_i, id_fence_i, ex_ready_i,
           wb_valid_i, wb_rd_i, wb_wen_i, wb_ebreak_i, redirect_i,
    input  issue_ok_o, flush_o, halted_o, inflight_o, state_o
  );

  modport slave (
    input  id_valid_i, id_rs1_i, id_rs2_i, id_rs1_en_i, id_rs2_en_i,
           id_rd_i, id_rd_wen_i, id_fence_i, ex_ready_i,
           wb_valid_i, wb_rd_i, wb_wen_i, wb_ebreak_i, redirect_i,
    output issue_ok_o, flush_o, halted_o, inflight_o, state_o
  );

endinterface

// File: rtl/pipe_hazard_ctrl_scoreboard.sv
// Per-register count of in-flight writers, with pending lookups for ID.
module hz_scoreboard #(
  parameter int NUM_REGS     = liang_pkg::HZ_NUM_REGS,
  parameter int MAX_INFLIGHT = liang_pkg::HZ_MAX_INFLIGHT,
  parameter int CW           = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       inc_i,
  input  logic [4:0] inc_rd_i,
  input  logic       dec_i,
  input  logic [4:0] dec_rd_i,
  input  logic [4:0] rs1_i,
  input  logic [4:0] rs2_i,
  input  logic [4:0] rd_i,
  output logic       rs1_busy_o,
  output logic       rs2_busy_o,
  output logic       rd_full_o
);

  logic [CW-1:0] cnt_q [NUM_REGS];
  logic [CW-1:0] cnt_d [NUM_REGS];
  logic          inc_err;
  logic          dec_err;

  // Next counts: inc and dec on the same register cancel; x0 stays zero.
  always_comb begin
    cnt_d   = cnt_q;
    inc_err = 1'b0;
    dec_err = 1'b0;
    for (int r = 1; r < NUM_REGS; r++) begin
      if (inc_i && inc_rd_i == 5'(r) && !(dec_i && dec_rd_i == 5'(r))) begin
        if (cnt_q[r] == CW'(MAX_INFLIGHT)) inc_err = 1'b1;
        else                               cnt_d[r] = cnt_q[r] + 1'b1;
      end else if (dec_i && dec_rd_i == 5'(r) && !(inc_i && inc_rd_i == 5'(r))) begin
        if (cnt_q[r] == '0) dec_err = 1'b1;
        else                cnt_d[r] = cnt_q[r] - 1'b1;
      end
    end
    cnt_d[0] = '0;
  end

  // Counter array register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign rs1_busy_o = (cnt_q[rs1_i] != '0);
  assign rs2_busy_o = (cnt_q[rs2_i] != '0);
  assign rd_full_o  = (cnt_q[rd_i] == CW'(MAX_INFLIGHT));

  a_no_overflow:  assert property (@(posedge clk_i) disable iff (rst_i) !inc_err);
  a_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i) !dec_err);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Issue controller: RAW stall, fence drain, redirect flush and ebreak halt.
module pipe_hazard_ctrl
  import liang_pkg::*;
#(
  parameter int NUM_REGS     = HZ_NUM_REGS,
  parameter int MAX_INFLIGHT = HZ_MAX_INFLIGHT
) (
  input  logic             clk_i,
  input  logic             rst_i,
  pipe_hazard_ctrl_if.slave bus
);

  localparam int CW = $clog2(MAX_INFLIGHT + 1);

  hz_state_e     state_q, state_d;
  logic          flush_q, flush_d;
  logic          halted_q, halted_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic          rs1_busy, rs2_busy, rd_full;
  logic          hazard, issue_ok, issue, retire;
  logic          infl_err;

  hz_scoreboard #(
    .NUM_REGS     (NUM_REGS),
    .MAX_INFLIGHT (MAX_INFLIGHT),
    .CW           (CW)
  ) u_sb (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .inc_i      (issue && bus.id_rd_wen_i),
    .inc_rd_i   (bus.id_rd_i),
    .dec_i      (bus.wb_valid_i && bus.wb_wen_i),
    .dec_rd_i   (bus.wb_rd_i),
    .rs1_i      (bus.id_rs1_i),
    .rs2_i      (bus.id_rs2_i),
    .rd_i       (bus.id_rd_i),
    .rs1_busy_o (rs1_busy),
    .rs2_busy_o (rs2_busy),
    .rd_full_o  (rd_full)
  );

  // Issue gating, in-flight count and next FSM state from registered state.
  always_comb begin
    hazard = (bus.id_rs1_en_i && rs1_busy) || (bus.id_rs2_en_i && rs2_busy) ||
             (bus.id_rd_wen_i && rd_full) || (inflight_q == CW'(MAX_INFLIGHT));
    issue_ok = 1'b0;
    if (state_q == HZ_RUN) begin
      issue_ok = bus.id_valid_i && !hazard &&
                 !(bus.id_fence_i && inflight_q != '0) && !bus.redirect_i;
    end
    issue  = bus.id_valid_i && issue_ok && bus.ex_ready_i;
    retire = bus.wb_valid_i;

    inflight_d = inflight_q;
    infl_err   = 1'b0;
    if (issue && !retire) begin
      if (inflight_q == CW'(MAX_INFLIGHT)) infl_err = 1'b1;
      else                                 inflight_d = inflight_q + 1'b1;
    end else if (retire && !issue) begin
      if (inflight_q == '0) infl_err = 1'b1;
      else                  inflight_d = inflight_q - 1'b1;
    end

    state_d = state_q;
    if (bus.wb_valid_i && bus.wb_ebreak_i) begin
      state_d = HZ_HALT;
    end else begin
      case (state_q)
        HZ_RUN:   if (bus.redirect_i) state_d = HZ_FLUSH;
        HZ_FLUSH: state_d = HZ_RUN;   // a redirect seen here is already flushed
        default:  state_d = state_q;
      endcase
    end
    flush_d  = (state_d == HZ_FLUSH);
    halted_d = (state_d == HZ_HALT);
  end

  // FSM, registered status outputs and in-flight counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= HZ_RUN;
      flush_q    <= 1'b0;
      halted_q   <= 1'b0;
      inflight_q <= '0;
    end else begin
      state_q    <= state_d;
      flush_q    <= flush_d;
      halted_q   <= halted_d;
      inflight_q <= inflight_d;
    end
  end

  assign bus.issue_ok_o = issue_ok;
  assign bus.flush_o    = flush_q;
  assign bus.halted_o   = halted_q;
  assign bus.inflight_o = inflight_q;
  assign bus.state_o    = state_q;

  a_inflight_range: assert property (@(posedge clk_i) disable iff (rst_i) !infl_err);

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: RAW stall, same-cycle inc/dec,
// redirect flush, fence drain, in-flight limit, ebreak halt and reset.
module tb_pipe_hazard_ctrl;
  import liang_pkg::*;

  // Clock / reset
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  pipe_hazard_ctrl_if bus ();

  pipe_hazard_ctrl dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    bus.id_valid_i  = 1'b0;
    bus.id_rs1_i    = '0;
    bus.id_rs2_i    = '0;
    bus.id_rs1_en_i = 1'b0;
    bus.id_rs2_en_i = 1'b0;
    bus.id_rd_i     = '0;
    bus.id_rd_wen_i = 1'b0;
    bus.id_fence_i  = 1'b0;
    bus.ex_ready_i  = 1'b1;
    bus.wb_valid_i  = 1'b0;
    bus.wb_rd_i     = '0;
    bus.wb_wen_i    = 1'b0;
    bus.wb_ebreak_i = 1'b0;
    bus.redirect_i  = 1'b0;
  endtask

  task automatic id_set(input logic v, input logic [4:0] rs1, input logic rs1_en,
                        input logic [4:0] rs2, input logic rs2_en,
                        input logic [4:0] rd, input logic wen, input logic fence);
    bus.id_valid_i  = v;
    bus.id_rs1_i    = rs1;
    bus.id_rs1_en_i = rs1_en;
    bus.id_rs2_i    = rs2;
    bus.id_rs2_en_i = rs2_en;
    bus.id_rd_i     = rd;
    bus.id_rd_wen_i = wen;
    bus.id_fence_i  = fence;
  endtask

  task automatic wb_set(input logic v, input logic [4:0] rd, input logic wen, input logic ebreak);
    bus.wb_valid_i  = v;
    bus.wb_rd_i     = rd;
    bus.wb_wen_i    = wen;
    bus.wb_ebreak_i = ebreak;
  endtask

  // Reset sequence: synchronous, held for two edges.
  task automatic do_reset();
    idle_inputs();
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  initial begin
    do_reset();

    // ---- reset state ----
    settle();
    check("rst_flush", 32'(bus.flush_o), 0);
    check("rst_halted", 32'(bus.halted_o), 0);
    check("rst_inflight", 32'(bus.inflight_o), 0);
    check("rst_state", 32'(bus.state_o), 32'(HZ_RUN));
    check("rst_ok_novalid", 32'(bus.issue_ok_o), 0);
    id_set(1, 5'd3, 1, 5'd4, 1, 5'd0, 0, 0);
    bus.ex_ready_i = 1'b0;   // look only, no issue
    settle();
    check("rst_ok_valid", 32'(bus.issue_ok_o), 1);
    idle_inputs();

    // ---- RAW stall on x5 ----
    id_set(1, 5'd0, 0, 5'd0, 0, 5'd5, 1, 0);                 // t0: writer x5
    settle();
    check("raw_t0_ok", 32'(bus.issue_ok_o), 1);
    tick();
    id_set(1, 5'd5, 1, 5'd0, 0, 5'd0, 0, 0);                 // t1: reader x5
    settle();
    check("raw_t1_ok", 32'(bus.issue_ok_o), 0);
    check("raw_t1_infl", 32'(bus.inflight_o), 1);
    tick();
    settle();
    check("raw_t2_ok", 32'(bus.issue_ok_o), 0);
    tick();
    wb_set(1, 5'd5, 1, 0);                                   // t3: WB x5
    settle();
    check("raw_t3_ok", 32'(bus.issue_ok_o), 0);
    tick();
    wb_set(0, 5'd0, 0, 0);                                   // t4: freed
    settle();
    check("raw_t4_ok", 32'(bus.issue_ok_o), 1);
    tick();                                                  // reader issued
    idle_inputs();
    check("raw_infl_after", 32'(bus.inflight_o), 1);
    wb_set(1, 5'd0, 0, 0);                                   // retire reader
    tick();
    idle_inputs();
    check("raw_drained", 32'(bus.inflight_o), 0);

    // ---- same-cycle issue and retire of x7 ----
    id_set(1, 5'd0, 0, 5'd0, 0, 5'd7, 1, 0);                 // writer A of x7
    tick();
    id_set(1, 5'd0, 0, 5'd0, 0, 5'd7, 1, 0);                 // writer B of x7
    wb_set(1, 5'd7, 1, 0);                                   // A retires
    settle();
    check("x7_b_ok", 32'(bus.issue_ok_o), 1);
    tick();
    wb_set(0, 5'd0, 0, 0);
    id_set(1, 5'd0, 0, 5'd7, 1, 5'd0, 0, 0);                 // reader x7 on rs2
    settle();
    check("x7_infl_same", 32'(bus.inflight_o), 1);
    check("x7_rd_stall", 32'(bus.issue_ok_o), 0);
    wb_set(1, 5'd7, 1, 0);                                   // B retires
    settle();
    check("x7_wb_nobypass", 32'(bus.issue_ok_o), 0);
    tick();
    wb_set(0, 5'd0, 0, 0);
    settle();
    check("x7_rd_free", 32'(bus.issue_ok_o), 1);
    bus.ex_ready_i = 1'b0;                                   // EX busy: hold in ID
    tick();
    check("x7_exready_hold", 32'(bus.inflight_o), 0);
    idle_inputs();

    // ---- redirect flush (second redirect during FLUSH is ignored) ----
    id_set(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0);
    bus.ex_ready_i = 1'b0;
    bus.redirect_i = 1'b1;                                   // t0
    settle();
    check("rdr_t0_ok", 32'(bus.issue_ok_o), 0);
    check("rdr_t0_flush", 32'(bus.flush_o), 0);
    tick();
    settle();                                                // t1, redirect still high
    check("rdr_t1_ok", 32'(bus.issue_ok_o), 0);
    check("rdr_t1_flush", 32'(bus.flush_o), 1);
    check("rdr_t1_state", 32'(bus.state_o), 32'(HZ_FLUSH));
    tick();
    bus.redirect_i = 1'b0;                                   // t2
    settle();
    check("rdr_t2_flush", 32'(bus.flush_o), 0);
    check("rdr_t2_state", 32'(bus.state_o), 32'(HZ_RUN));
    check("rdr_t2_ok", 32'(bus.issue_ok_o), 1);
    idle_inputs();

    // ---- fence waits for two in-flight instructions ----
    id_set(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0);
    tick();
    tick();
    id_set(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1);                 // fence in ID
    settle();
    check("fence_infl2", 32'(bus.inflight_o), 2);
    check("fence_blk2", 32'(bus.issue_ok_o), 0);
    wb_set(1, 5'd0, 0, 0);
    tick();
    settle();
    check("fence_blk1", 32'(bus.issue_ok_o), 0);
    tick();
    wb_set(0, 5'd0, 0, 0);
    settle();
    check("fence_go", 32'(bus.issue_ok_o), 1);
    tick();                                                  // fence issued
    idle_inputs();
    check("fence_infl1", 32'(bus.inflight_o), 1);
    wb_set(1, 5'd0, 0, 0);
    tick();
    idle_inputs();

    // ---- three writers of x1, then limit reached ----
    for (int i = 0; i < 3; i++) begin
      id_set(1, 5'd0, 0, 5'd0, 0, 5'd1, 1, 0);
      settle();
      check($sformatf("x1_w%0d_ok", i), 32'(bus.issue_ok_o), 1);
      tick();
    end
    id_set(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0);
    settle();
    check("max_infl", 32'(bus.inflight_o), 3);
    check("max_plain_blk", 32'(bus.issue_ok_o), 0);
    id_set(1, 5'd0, 0, 5'd0, 0, 5'd1, 1, 0);
    settle();
    check("max_x1_blk", 32'(bus.issue_ok_o), 0);
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      wb_set(1, 5'd1, 1, 0);
      tick();
    end
    idle_inputs();
    check("x1_drained", 32'(bus.inflight_o), 0);

    // ---- reset during FLUSH ----
    bus.redirect_i = 1'b1;
    tick();
    bus.redirect_i = 1'b0;
    check("pre_rst_flush", 32'(bus.flush_o), 1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("rst_mid_flush", 32'(bus.flush_o), 0);
    check("rst_mid_state", 32'(bus.state_o), 32'(HZ_RUN));

    // ---- ebreak halt: A=ebreak, B writes x9, C writes x10 ----
    id_set(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0);
    tick();
    id_set(1, 5'd0, 0, 5'd0, 0, 5'd9, 1, 0);
    tick();
    id_set(1, 5'd0, 0, 5'd0, 0, 5'd10, 1, 0);
    tick();
    idle_inputs();
    wb_set(1, 5'd0, 0, 1);                                   // A retires as ebreak
    settle();
    check("ebrk_t_halted", 32'(bus.halted_o), 0);
    tick();
    wb_set(1, 5'd9, 1, 0);                                   // B retires in HALT
    check("ebrk_halted", 32'(bus.halted_o), 1);
    check("ebrk_state", 32'(bus.state_o), 32'(HZ_HALT));
    check("ebrk_infl", 32'(bus.inflight_o), 2);
    tick();
    wb_set(0, 5'd0, 0, 0);
    check("halt_retire", 32'(bus.inflight_o), 1);
    id_set(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      bus.redirect_i = (i % 3 == 0);
      settle();
      check($sformatf("halt_ok_%0d", i), 32'(bus.issue_ok_o), 0);
      check($sformatf("halt_flush_%0d", i), 32'(bus.flush_o), 0);
      tick();
    end
    check("halt_sticky", 32'(bus.halted_o), 1);
    idle_inputs();
    rst_i = 1'b1;                                            // C's x10 still counted
    tick();
    rst_i = 1'b0;
    check("post_rst_halted", 32'(bus.halted_o), 0);
    check("post_rst_state", 32'(bus.state_o), 32'(HZ_RUN));
    check("post_rst_infl", 32'(bus.inflight_o), 0);
    id_set(1, 5'd10, 1, 5'd9, 1, 5'd10, 1, 0);
    bus.ex_ready_i = 1'b0;
    settle();
    check("post_rst_x10_free", 32'(bus.issue_ok_o), 1);
    idle_inputs();
    tick();

    // Final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Watchdog: the directed sequence is a few hundred cycles at most.
  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Issue controller for the in-order pipeline, between the decode stage and execute. Tracks in-flight destination registers in a per-register scoreboard and blocks issue on RAW hazards. Sequences pipeline-wide events: one-cycle front-end flush on an EX redirect, full drain before fence-class instructions, and a sticky halt on a retired ebreak.

## Interface

Parameters:
- NUM_REGS, 32: architectural integer registers; x0 is never tracked.
- MAX_INFLIGHT, 3: maximum writers in flight past ID (EX, MEM, WB). Counter width CW = $clog2(MAX_INFLIGHT+1).

Ports:
- clk_i  in  1  clock; single clock domain.
- rst_i  in  1  reset, synchronous, active-high.
- id_valid_i  in  1  decoded instruction present in ID.
- id_rs1_i / id_rs2_i  in  5  source register indices.
- id_rs1_en_i / id_rs2_en_i  in  1  source actually read.
- id_rd_i  in  5  destination index.
- id_rd_wen_i  in  1  instruction writes rd.
- id_fence_i  in  1  instruction requires an empty pipeline before issue.
- ex_ready_i  in  1  EX accepts an instruction this cycle.
- issue_ok_o  out  1  ID may present valid to EX (gates id_valid toward EX).
- wb_valid_i  in  1  an instruction retires this cycle.
- wb_rd_i  in  5  retiring destination.
- wb_wen_i  in  1  retiring instruction writes rd.
- wb_ebreak_i  in  1  retiring instruction is ebreak.
- redirect_i  in  1  EX redirect (taken branch or jump).
- flush_o  out  1  flush IF/ID stage registers.
- halted_o  out  1  core halted.
- inflight_o  out  CW  total issued-but-not-retired instructions.

## Operation

- Scoreboard: cnt[r], CW bits, for r = 1..NUM_REGS-1. cnt[0] is constant 0.
- issue = id_valid_i && issue_ok_o && ex_ready_i.
- On issue with id_rd_wen_i and id_rd_i != 0: cnt[rd] +1.
- On wb_valid_i && wb_wen_i && wb_rd_i != 0: cnt[wb_rd] -1.
- Both events on the same register in the same cycle: cnt unchanged.
- Global counter inflight: +1 on issue, -1 on wb_valid_i. Both in the same cycle: unchanged.
- hazard = (id_rs1_en_i && cnt[rs1] != 0) || (id_rs2_en_i && cnt[rs2] != 0) || (id_rd_wen_i && cnt[rd] == MAX_INFLIGHT) || inflight == MAX_INFLIGHT.
  - Uses registered counts only. There is no same-cycle WB bypass.
- FSM states:
  - RUN: issue_ok_o = id_valid_i && !hazard && !(id_fence_i && inflight != 0) && !redirect_i.
  - FLUSH: flush_o = 1; issue_ok_o = 0. Lasts exactly one cycle, then RUN.
  - HALT: issue_ok_o = 0, halted_o = 1. Scoreboard keeps retiring. Exits only on rst_i.
- Transition priority, evaluated each cycle:
  1. wb_ebreak_i && wb_valid_i -> HALT, from any state.
  2. redirect_i in RUN -> FLUSH.
  3. Otherwise hold.
- A redirect_i that arrives while in FLUSH is ignored; EX has already been flushed by then.
- A fence waits in RUN with issue blocked while inflight != 0. It issues normally in the first cycle inflight == 0. No separate state is needed.
- A decrement of a zero counter, or an increment past MAX_INFLIGHT, is a design error. Flag it with an assertion and saturate.

## Timing

- Reset: all cnt = 0, inflight = 0, state RUN, flush_o = 0, halted_o = 0. issue_ok_o then depends only on id_valid_i.
- rst_i takes effect at the next posedge regardless of state, including mid-FLUSH or HALT.
- issue_ok_o is combinational from inputs and registered state, with zero latency.
- Scoreboard and FSM update at the posedge after the events.
- redirect_i at cycle t: issue_ok_o = 0 at t; flush_o = 1 at t+1 only; RUN at t+2.
- A RAW consumer stalls until the cycle after its producer's WB cycle.
- ebreak retire at t: halted_o = 1 from t+1.

## Structure

- Put in liang_pkg:
  - typedef hz_state_e {HZ_RUN, HZ_FLUSH, HZ_HALT}.
  - localparam HZ_MAX_INFLIGHT.
- One sub-module is natural: hz_scoreboard. It holds the counter array, the inc/dec logic and the pending lookups for rs1/rs2/rd.
- The FSM and inflight counter live in the top module.

## Test plan

- RAW stall: issue x5 writer at t0, consumer of x5 in ID at t1; WB of x5 at t3. Expect issue_ok_o = 0 for t1..t3, = 1 at t4.
- Same-cycle issue and retire of x7 with cnt[7] = 1: expect cnt[7] stays 1, and an x7 consumer still stalls.
- Redirect at t0 with id_valid_i = 1: expect issue_ok_o = 0 at t0 and t1, flush_o = 1 only at t1, issue resumes at t2.
- Fence with inflight = 2: expect issue blocked until two WBs retire, then issue in the first cycle inflight = 0.
- Retired ebreak: halted_o = 1 next cycle, issue_ok_o held 0 for 10 cycles, then rst_i for one cycle restores RUN with all counts 0.
- Three back-to-back writers of x1 with no WB: expect the third issues and a fourth instruction of any kind is blocked (inflight = MAX).
